// File: rtl/disp_arbiter.sv
// disp_arbiter
//   Round-robin time-slice arbiter that shares one 4-digit 7-segment display
//   among four requesters. One owner at a time has its 16-bit value
//   registered onto dispVal. Ownership rotates when the slice expires or
//   when the owner drops its request.
//
// Ports
//   clk5      in   1   5 MHz system clock
//   reset     in   1   asynchronous, active-high reset
//   req       in   4   level request per requester
//   reqVal    in  64   requester n value at [16n+15:16n]
//   dispVal   out 16   registered display value (IDLE_VAL when idle)
//   grant     out  4   one-hot owner, zero when idle
//   owner     out  2   current or most recent owner index
//   switched  out  1   one-cycle pulse on every grant change
module disp_arbiter #(
  parameter int          SLICE    = 5000000,
  parameter int          CNT_W    = 23,
  parameter logic [15:0] IDLE_VAL = 16'h0000
) (
  input  logic        clk5,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [63:0] reqVal,
  output logic [15:0] dispVal,
  output logic [3:0]  grant,
  output logic [1:0]  owner,
  output logic        switched
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state_reg, state_next;
  logic [15:0]        disp_reg, disp_next;
  logic [3:0]         grant_reg, grant_next;
  logic [1:0]         owner_reg, owner_next;
  logic               sw_reg, sw_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICE - 1);

  // Per-requester value view of the packed input bus.
  logic [15:0] val_arr [4];
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_val
      assign val_arr[gi] = reqVal[16*gi +: 16];
    end
  endgenerate

  // Round-robin winner: search starts after the current owner and the owner
  // itself is visited last, so it only wins when nobody else is asking.
  logic [1:0] win;
  logic       any_req;
  always_comb begin
    logic [1:0] idx;
    logic       found;
    win   = owner_reg;
    found = 1'b0;
    idx   = owner_reg;
    for (int k = 1; k <= 4; k++) begin
      idx = owner_reg + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
  assign any_req = |req;

  always_comb begin
    state_next = state_reg;
    disp_next  = disp_reg;
    grant_next = grant_reg;
    owner_next = owner_reg;
    sw_next    = 1'b0;
    cnt_next   = cnt_reg;

    case (state_reg)
      IDLE: begin
        disp_next = IDLE_VAL;
        if (any_req) begin
          state_next = HOLD;
          owner_next = win;
          grant_next = 4'b0001 << win;
          disp_next  = val_arr[win];
          cnt_next   = '0;
          sw_next    = 1'b1;
        end
      end
      HOLD: begin
        if (!req[owner_reg]) begin
          // Owner released: any remaining request is necessarily another
          // requester, so hand over directly without an idle gap.
          if (any_req) begin
            owner_next = win;
            grant_next = 4'b0001 << win;
            disp_next  = val_arr[win];
            cnt_next   = '0;
            sw_next    = 1'b1;
          end else begin
            state_next = IDLE;
            grant_next = 4'b0000;
            disp_next  = IDLE_VAL;
            cnt_next   = '0;
            sw_next    = 1'b1;
          end
        end else if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (win != owner_reg) begin
            owner_next = win;
            grant_next = 4'b0001 << win;
            disp_next  = val_arr[win];
            sw_next    = 1'b1;
          end else begin
            // Sole requester keeps the display for another slice.
            disp_next = val_arr[owner_reg];
          end
        end else begin
          cnt_next  = cnt_reg + 1'b1;
          disp_next = val_arr[owner_reg];
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      disp_reg  <= IDLE_VAL;
      grant_reg <= 4'b0000;
      owner_reg <= 2'd3;
      sw_reg    <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      disp_reg  <= disp_next;
      grant_reg <= grant_next;
      owner_reg <= owner_next;
      sw_reg    <= sw_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign dispVal  = disp_reg;
  assign grant    = grant_reg;
  assign owner    = owner_reg;
  assign switched = sw_reg;

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed testbench for disp_arbiter with SLICE=8.
module tb_disp_arbiter;

  logic        clk5;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] reqVal;
  logic [15:0] dispVal;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        switched;

  int total;
  int bad;

  disp_arbiter #(.SLICE(8), .CNT_W(4), .IDLE_VAL(16'h0000)) dut (
    .clk5     (clk5),
    .reset    (reset),
    .req      (req),
    .reqVal   (reqVal),
    .dispVal  (dispVal),
    .grant    (grant),
    .owner    (owner),
    .switched (switched)
  );

  initial clk5 = 1'b0;
  always #5 clk5 = ~clk5;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // One clock edge; outputs are then sampled on the following falling edge.
  task automatic tick();
    @(posedge clk5);
    @(negedge clk5);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int sw_count;
    int gchg;
    logic [15:0] vals [4];
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    req    = 4'b0000;
    reqVal = 64'h0;
    @(negedge clk5);

    // Reset state
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_disp", 64'(dispVal), 64'h0);
    chk("rst_owner", 64'(owner), 64'd3);
    chk("rst_sw", 64'(switched), 64'h0);
    reset = 1'b0;

    // Single requester
    req = 4'b0010;
    reqVal[31:16] = 16'hBEEF;
    tick();
    chk("t2_grant", 64'(grant), 64'h2);
    chk("t2_disp", 64'(dispVal), 64'hBEEF);
    chk("t2_sw", 64'(switched), 64'h1);
    chk("t2_owner", 64'(owner), 64'd1);
    sw_count = 0;
    gchg = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (switched) sw_count++;
      if (grant != 4'b0010) gchg++;
    end
    chk("t2_hold_sw", 64'(sw_count), 64'd0);
    chk("t2_hold_grant", 64'(gchg), 64'd0);
    reqVal[31:16] = 16'h1234;
    tick();
    chk("t2_newval", 64'(dispVal), 64'h1234);
    req = 4'b0000;
    tick();
    chk("t2_idle_grant", 64'(grant), 64'h0);
    chk("t2_idle_disp", 64'(dispVal), 64'h0);
    chk("t2_idle_sw", 64'(switched), 64'h1);
    chk("t2_idle_owner", 64'(owner), 64'd1);
    tick();
    chk("t2_idle_sw2", 64'(switched), 64'h0);

    // Simultaneous requests from idle
    pulse_reset();
    reqVal = {16'h0000, 16'h3333, 16'h0000, 16'h1111};
    req = 4'b0101;
    for (int i = 0; i < 24; i++) begin
      tick();
      chk($sformatf("t3_grant[%0d]", i), 64'(grant),
          ((i / 8) % 2 == 0) ? 64'h1 : 64'h4);
      chk($sformatf("t3_disp[%0d]", i), 64'(dispVal),
          ((i / 8) % 2 == 0) ? 64'h1111 : 64'h3333);
      chk($sformatf("t3_sw[%0d]", i), 64'(switched), (i % 8 == 0) ? 64'h1 : 64'h0);
    end

    // Full rotation
    pulse_reset();
    vals[0] = 16'h000A; vals[1] = 16'h000B; vals[2] = 16'h000C; vals[3] = 16'h000D;
    reqVal = {vals[3], vals[2], vals[1], vals[0]};
    req = 4'b1111;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk($sformatf("t4_disp[%0d]", i), 64'(dispVal), 64'(vals[(i / 8) % 4]));
      chk($sformatf("t4_grant[%0d]", i), 64'(grant), 64'(4'b0001 << ((i / 8) % 4)));
    end

    // Early release
    pulse_reset();
    reqVal = {16'h4444, 16'h2222, 16'h0000, 16'h0000};
    req = 4'b0100;
    tick();
    chk("t5_grant0", 64'(grant), 64'h4);
    tick(); tick(); tick();
    chk("t5_grant3", 64'(grant), 64'h4);
    chk("t5_disp3", 64'(dispVal), 64'h2222);
    req = 4'b1000;
    tick();
    chk("t5_rel_grant", 64'(grant), 64'h8);
    chk("t5_rel_disp", 64'(dispVal), 64'h4444);
    chk("t5_rel_sw", 64'(switched), 64'h1);
    chk("t5_rel_owner", 64'(owner), 64'd3);
    sw_count = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (switched) sw_count++;
    end
    chk("t5_hold_sw", 64'(sw_count), 64'd0);
    req = 4'b0000;
    tick();
    chk("t5_idle_grant", 64'(grant), 64'h0);
    chk("t5_idle_disp", 64'(dispVal), 64'h0);
    chk("t5_idle_owner", 64'(owner), 64'd3);
    chk("t5_idle_sw", 64'(switched), 64'h1);

    // Release coincident with expiry
    pulse_reset();
    reqVal = {16'h0000, 16'h0000, 16'h6666, 16'h5555};
    req = 4'b0001;
    tick();
    chk("t6_grant0", 64'(grant), 64'h1);
    for (int i = 0; i < 7; i++) tick();
    chk("t6_grant7", 64'(grant), 64'h1);
    chk("t6_sw7", 64'(switched), 64'h0);
    req = 4'b0010;
    tick();
    chk("t6_sw_grant", 64'(grant), 64'h2);
    chk("t6_sw_disp", 64'(dispVal), 64'h6666);
    chk("t6_sw_pulse", 64'(switched), 64'h1);
    tick();
    chk("t6_after_grant", 64'(grant), 64'h2);
    chk("t6_after_sw", 64'(switched), 64'h0);

    // Asynchronous reset mid-slice
    pulse_reset();
    reqVal = {16'h0000, 16'h7777, 16'h8888, 16'h0000};
    req = 4'b0100;
    tick();
    chk("t1_pre_grant", 64'(grant), 64'h4);
    chk("t1_pre_sw", 64'(switched), 64'h1);
    reset = 1'b1;
    #1;
    chk("t1_async_grant", 64'(grant), 64'h0);
    chk("t1_async_disp", 64'(dispVal), 64'h0);
    chk("t1_async_sw", 64'(switched), 64'h0);
    chk("t1_async_owner", 64'(owner), 64'd3);
    req = 4'b0110;
    reset = 1'b0;
    tick();
    chk("t1_first_grant", 64'(grant), 64'h2);
    chk("t1_first_disp", 64'(dispVal), 64'h8888);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_arbiter.md
Name: disp_arbiter

Overview:
- Round-robin time-slice arbiter that shares the single 4-digit 7-segment display interface among four requesters. Example requesters: debug counters, status word, error code, user value.
- Selects one owner, registers that owner's 16-bit value onto the dispVal bus of the display interface, and rotates ownership after a fixed slice or when the owner releases.
- Sits between the application logic and the display interface, in the same 5 MHz clock domain.

Parameters:
- SLICE, 5000000, slice length in clk5 cycles (1 s at 5 MHz); legal range 2..2^CNT_W.
- CNT_W, 23, slice counter width.
- IDLE_VAL, 16'h0000, value driven on dispVal when no requester owns the display.

Ports:
- clk5  input  1  5 MHz system clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request per requester; level-held while the requester wants the display.
- reqVal  input  64  requester values; requester n occupies bits [16n+15:16n].
- dispVal  output  16  registered value for the display interface.
- grant  output  4  one-hot owner indication; all zero when idle.
- owner  output  2  index of the current or most recent owner.
- switched  output  1  one-cycle pulse on every change of grant, including to and from idle.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, active-high):
  - state=IDLE, grant=0, dispVal=IDLE_VAL, owner=3, switched=0, slice counter=0.
  - owner=3 at reset makes req[0] the first winner.
- Arbitration function:
  - Search order starts at owner+1 mod 4 and wraps.
  - The current owner is examined last, so it has lowest priority.
  - Winner = first index with req set in that order.
- States: IDLE and HOLD.
- IDLE:
  - dispVal holds IDLE_VAL.
  - If any req bit is 1 at a clk5 edge, on that edge: state->HOLD, owner<=winner, grant<=onehot(winner), dispVal<=reqVal[winner], counter<=0, switched<=1.
  - Latency from req assertion to grant/dispVal is 1 cycle.
- HOLD, evaluated each edge in this priority:
  1. req[owner]==0 (release):
     - If any other req is set, switch directly to the winner: grant, owner and dispVal update, counter<=0, switched<=1.
     - Otherwise: state->IDLE, grant<=0, dispVal<=IDLE_VAL, switched<=1. owner keeps its last value for round-robin.
     - Release may occur at any point in the slice. There is no minimum dwell.
  2. counter==SLICE-1 (slice expiry):
     - Re-arbitrate with the owner lowest priority.
     - If the winner differs from the owner, switch as above.
     - If the owner is the only requester, it keeps the display: counter<=0, switched stays 0, no gap cycle.
  3. Otherwise: counter<=counter+1, dispVal<=reqVal[owner].
     - dispVal tracks the owner's live value with 1-cycle latency.
- Timing:
  - switched is 0 on every edge except those listed above.
  - grant and dispVal change on the same edge. There is never a cycle in which grant names one owner and dispVal carries another owner's value.
  - The slice counter never exceeds SLICE-1. It wraps only by being reset to 0.
- Simultaneous events:
  - Release and expiry in the same cycle: release rules apply.
  - req bits of non-owners changing mid-slice have no effect until release or expiry. There is no preemption.
- reqVal changes of non-owners are ignored.
- Reset asserted mid-slice returns all outputs to reset values immediately (asynchronous). After deassertion, arbitration restarts from req[0] priority.
- Output constraints: grant is always zero or one-hot. owner is valid whenever grant!=0.

Test Plan:
1. Reset: assert reset mid-run while grant=4'b0100 -> grant=0, dispVal=16'h0000, switched=0 with no clock edge; after release with req=4'b0110, first grant=4'b0010.
2. Single requester (SLICE=8): req=4'b0010, reqVal[31:16]=16'hBEEF -> next edge grant=4'b0010, dispVal=16'hBEEF, switched=1 for one cycle; held for 40 cycles with no further switched pulse; change value to 16'h1234 -> dispVal=16'h1234 one cycle later.
3. Simultaneous requests from idle (SLICE=8): req=4'b0101 -> grant=4'b0001 for 8 cycles, then grant=4'b0100 for 8 cycles, then 4'b0001 again; switched pulses exactly at each change.
4. Full rotation (SLICE=8): req=4'b1111, values 16'h000A/000B/000C/000D -> dispVal sequence A,B,C,D,A with each value lasting exactly 8 cycles.
5. Early release: owner 2 drops req at count 3 while req[3]=1 -> next edge grant=4'b1000, dispVal=reqVal[63:48], counter restarts; then drop all req -> grant=0, dispVal=16'h0000, owner stays 3.
6. Release coincident with expiry: owner 0 drops req on the cycle its counter reaches 7, req[1]=1 -> grant=4'b0010 on that edge, single switched pulse, no idle cycle.
